// File: rtl/alu_issue_seq.sv
// alu_issue_seq -- fetch/decode/issue sequencer for the 9-bit ISA datapath.
//
// This block fetches 9-bit instructions over a req/ack instruction-memory
// port. It decodes each instruction into register-file addresses and ALU
// controls. It takes branches from the ALU condition flag, and it halts on
// the terminate condition (branch class with cond == 3'b111).
//
// Instruction format:
//   IR[8] = 0  ALU class    : op = IR[7:5], rd = IR[4:2], rs = IR[1:0]
//   IR[8] = 1  branch class : cond = IR[7:5], off = IR[4:0] (signed)
//
// Ports:
//   Clk, Reset            clock, asynchronous active-high reset
//   Start                 begin execution at RESET_PC (IDLE/HALT only)
//   imem_req/addr/ack/data instruction fetch handshake
//   rf_raddr_a/b, rf_waddr, rf_we   register-file control
//   alu_op, alu_cond, imm_sel, imm_val, cond_flag   ALU control / status
//   pc, busy, done, retired         status
//
// Optional feature: define ALU_ISSUE_RETIRE_CNT_EN to implement the 16-bit
// retired-instruction counter. When it is undefined, retired reads as zero
// and no counter flops exist.

package alu_issue_seq_pkg;
  // ALU opcodes the sequencer itself needs to know about.
  localparam logic [2:0] KADD  = 3'd0;
  localparam logic [2:0] KSUB  = 3'd1;
  localparam logic [2:0] KMOVI = 3'd5;

  // Branch condition that terminates the program.
  localparam logic [2:0] COND_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;
endpackage

module alu_issue_seq
  import alu_issue_seq_pkg::*;
#(
  parameter int              PW       = 8,
  parameter logic [PW-1:0]   RESET_PC = '0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  output logic          imem_req,
  output logic [PW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [8:0]    imem_data,
  output logic [2:0]    rf_raddr_a,
  output logic [2:0]    rf_raddr_b,
  output logic [2:0]    rf_waddr,
  output logic          rf_we,
  output logic [2:0]    alu_op,
  output logic [2:0]    alu_cond,
  output logic          imm_sel,
  output logic [7:0]    imm_val,
  input  logic          cond_flag,
  output logic [PW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [15:0]   retired
);

  state_t        state, state_nxt;
  logic [PW-1:0] pc_nxt;
  logic [8:0]    ir;
  logic          load_ir;

  logic          is_branch;
  logic          is_halt;
  logic [PW-1:0] branch_off;

  assign is_branch  = ir[8];
  assign is_halt    = is_branch && (ir[7:5] == COND_HALT);
  // Sign-extend the 5-bit offset to PC width. The add below wraps modulo 2^PW.
  assign branch_off = PW'($signed(ir[4:0]));

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (load_ir) ir <= imem_data;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    load_ir   = 1'b0;
    unique case (state)
      S_IDLE, S_HALT: begin
        if (Start) begin
          state_nxt = S_FETCH;
          pc_nxt    = RESET_PC;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          load_ir   = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (is_halt) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_FETCH;
          if (is_branch && cond_flag) pc_nxt = pc + branch_off;
          else                        pc_nxt = pc + PW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status and handshake outputs decode straight from the state register, so
  // an asynchronous reset removes rf_we and imem_req at once.
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign rf_we     = (state == S_EXEC) && !is_branch;
  assign busy      = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
  assign done      = (state == S_HALT);

  // Decode depends on IR alone, so the controls stay stable from DECODE
  // through EXEC even while a new fetch is pending.
  always_comb begin
    alu_op     = ir[7:5];
    alu_cond   = 3'd0;
    rf_raddr_a = ir[4:2];
    rf_raddr_b = {1'b0, ir[1:0]};
    rf_waddr   = ir[4:2];
    imm_sel    = (ir[7:5] == KMOVI);
    imm_val    = {6'b0, ir[1:0]};
    if (is_branch) begin
      // A branch compares r0 against r1 with a subtract. The ALU then
      // evaluates cond on that result.
      alu_op     = KSUB;
      alu_cond   = ir[7:5];
      rf_raddr_a = 3'd0;
      rf_raddr_b = 3'd1;
      rf_waddr   = 3'd0;
      imm_sel    = 1'b0;
      imm_val    = 8'd0;
    end
  end

`ifdef ALU_ISSUE_RETIRE_CNT_EN
  logic [15:0] retired_q;

  // Counts every EXEC cycle, including the halt. Only Reset clears it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                 retired_q <= 16'h0000;
    else if (state == S_EXEC)  retired_q <= retired_q + 16'd1;
  end

  assign retired = retired_q;
`else
  assign retired = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed testbench for alu_issue_seq. Expected decode results are queued
// when an instruction is handed to the fetch port. They are popped and
// compared when the sequencer reaches EXEC.
module tb_alu_issue_seq;
  import alu_issue_seq_pkg::*;

  localparam int          PW     = 8;
  localparam logic [7:0]  RST_PC = 8'h00;

  logic          Clk;
  logic          Reset;
  logic          Start;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack;
  logic [8:0]    imem_data;
  logic [2:0]    rf_raddr_a, rf_raddr_b, rf_waddr;
  logic          rf_we;
  logic [2:0]    alu_op, alu_cond;
  logic          imm_sel;
  logic [7:0]    imm_val;
  logic          cond_flag;
  logic [PW-1:0] pc;
  logic          busy, done;
  logic [15:0]   retired;

  alu_issue_seq #(.PW(PW), .RESET_PC(RST_PC)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .rf_raddr_a (rf_raddr_a),
    .rf_raddr_b (rf_raddr_b),
    .rf_waddr   (rf_waddr),
    .rf_we      (rf_we),
    .alu_op     (alu_op),
    .alu_cond   (alu_cond),
    .imm_sel    (imm_sel),
    .imm_val    (imm_val),
    .cond_flag  (cond_flag),
    .pc         (pc),
    .busy       (busy),
    .done       (done),
    .retired    (retired)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       is_alu;
    logic       halt;
    logic [2:0] op;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] waddr;
    logic [2:0] cond;
    logic       imm_sel;
    logic [7:0] imm_val;
    logic [7:0] next_pc;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          errors;
  logic [7:0]  m_pc;
  logic [15:0] m_ret;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] exp_retired();
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    return m_ret;
`else
    return 16'h0000;
`endif
  endfunction

  // Decode expectations taken directly from the instruction format.
  function automatic exp_t model(input logic [8:0] ins, input logic [7:0] next_pc);
    exp_t e;
    e.is_alu  = !ins[8];
    e.halt    = ins[8] && (ins[7:5] == 3'b111);
    e.next_pc = next_pc;
    if (!ins[8]) begin
      e.op      = ins[7:5];
      e.ra      = ins[4:2];
      e.rb      = {1'b0, ins[1:0]};
      e.waddr   = ins[4:2];
      e.cond    = 3'd0;
      e.imm_sel = (ins[7:5] == KMOVI);
      e.imm_val = {6'b0, ins[1:0]};
    end else begin
      e.op      = KSUB;
      e.ra      = 3'd0;
      e.rb      = 3'd1;
      e.waddr   = 3'd0;
      e.cond    = ins[7:5];
      e.imm_sel = 1'b0;
      e.imm_val = 8'd0;
    end
    return e;
  endfunction

  // Runs one instruction. The task is entered #1 after the edge that moved the
  // sequencer into FETCH, and it returns #1 after the edge that ends EXEC.
  // noisy: pulse Start during the wait cycles, and leave imem_ack high with
  // garbage data through DECODE and EXEC.
  task automatic run(input logic [8:0] ins, input int waits, input logic cf,
                     input logic [7:0] exp_next, input bit noisy);
    exp_t e;
    check("fetch_req", imem_req, 1);
    check("fetch_addr", imem_addr, m_pc);
    for (int i = 0; i < waits; i++) begin
      Start = noisy;
      @(posedge Clk); #1;
      check("wait_req", imem_req, 1);
      check("wait_addr", imem_addr, m_pc);
    end
    Start     = 1'b0;
    imem_ack  = 1'b1;
    imem_data = ins;
    sb.push_back(model(ins, exp_next));
    @(posedge Clk); #1;                       // DECODE
    if (noisy) begin
      imem_data = ~ins;
      Start     = 1'b1;
    end else begin
      imem_ack  = 1'b0;
    end
    check("decode_req", imem_req, 0);
    check("decode_we", rf_we, 0);
    check("decode_busy", busy, 1);
    cond_flag = ~cf;
    @(posedge Clk); #1;                       // EXEC
    cond_flag = cf;
    e = sb.pop_front();
    check("exec_we", rf_we, e.is_alu);
    check("exec_op", alu_op, e.op);
    check("exec_raddr_a", rf_raddr_a, e.ra);
    check("exec_raddr_b", rf_raddr_b, e.rb);
    check("exec_imm_sel", imm_sel, e.imm_sel);
    check("exec_pc", pc, m_pc);
    check("exec_busy", busy, 1);
    if (e.is_alu) begin
      check("exec_waddr", rf_waddr, e.waddr);
      check("exec_imm_val", imm_val, e.imm_val);
    end else begin
      check("exec_cond", alu_cond, e.cond);
    end
    m_ret = m_ret + 16'd1;
    @(posedge Clk); #1;                       // next FETCH or HALT
    imem_ack = 1'b0;
    Start    = 1'b0;
    check("next_pc", pc, e.next_pc);
    check("retired", retired, exp_retired());
    if (e.halt) begin
      check("halt_done", done, 1);
      check("halt_busy", busy, 0);
      check("halt_req", imem_req, 0);
    end else begin
      check("refetch_req", imem_req, 1);
      check("refetch_busy", busy, 1);
    end
    m_pc = e.next_pc;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    m_pc  = RST_PC;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    m_pc      = RST_PC;
    m_ret     = 16'h0000;
    Reset     = 1'b1;
    Start     = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 9'h000;
    cond_flag = 1'b0;

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", imem_req, 0);
    check("rst_we", rf_we, 0);
    check("rst_pc", pc, RST_PC);
    check("rst_retired", retired, 0);
    check("rst_op", alu_op, 0);
    check("rst_raddr_a", rf_raddr_a, 0);
    check("rst_raddr_b", rf_raddr_b, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_imm_sel", imm_sel, (KMOVI == 3'd0));

    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    check("idle_req", imem_req, 0);
    check("idle_busy", busy, 0);

    pulse_start();
    // ADD r3, r1 with ack on the first FETCH cycle.
    run({1'b0, KADD, 3'd3, 2'd1}, 0, 1'b0, 8'h01, 1'b0);
    // MOVI r2,#3 with 4 ack-wait cycles, Start pulses and spurious acks.
    run({1'b0, KMOVI, 3'd2, 2'd3}, 4, 1'b1, 8'h02, 1'b1);
    run({1'b0, KSUB, 3'd7, 2'd2}, 1, 1'b0, 8'h03, 1'b0);
    run({1'b0, 3'd4, 3'd5, 2'd0}, 0, 1'b1, 8'h04, 1'b0);
    run({1'b0, 3'd2, 3'd1, 2'd3}, 2, 1'b0, 8'h05, 1'b1);

    // beq -2 at pc 5: taken then not taken.
    run(9'b1_001_11110, 0, 1'b1, 8'h03, 1'b0);
    run({1'b0, 3'd3, 3'd4, 2'd1}, 0, 1'b0, 8'h04, 1'b0);
    run({1'b0, 3'd6, 3'd6, 2'd2}, 0, 1'b0, 8'h05, 1'b0);
    run(9'b1_001_11110, 0, 1'b0, 8'h06, 1'b0);
    run(9'b1_000_11110, 0, 1'b1, 8'h04, 1'b0);

    // Halt at pc 4; a set flag must not move the pc.
    run(9'b1_111_00000, 0, 1'b1, 8'h04, 1'b0);
    repeat (2) @(posedge Clk);
    #1;
    check("halt_hold_done", done, 1);
    check("halt_hold_pc", pc, 8'h04);

    pulse_start();
    check("restart_req", imem_req, 1);
    check("restart_addr", imem_addr, RST_PC);

    // Wrap-around in both directions, plus the offset-0 self-loop.
    run(9'b1_010_11111, 0, 1'b1, 8'hFF, 1'b0);
    run({1'b0, KADD, 3'd1, 2'd2}, 0, 1'b0, 8'h00, 1'b0);
    run(9'b1_010_11111, 0, 1'b1, 8'hFF, 1'b0);
    run(9'b1_011_00001, 0, 1'b1, 8'h00, 1'b0);
    run(9'b1_100_00000, 0, 1'b1, 8'h00, 1'b0);
    run(9'b1_010_11111, 1, 1'b1, 8'hFF, 1'b0);

    // Reset during EXEC of an ALU instruction at pc FF.
    imem_ack  = 1'b1;
    imem_data = {1'b0, KADD, 3'd2, 2'd1};
    @(posedge Clk); #1;
    imem_ack = 1'b0;
    @(posedge Clk); #1;
    check("pre_reset_we", rf_we, 1);
    check("pre_reset_pc", pc, 8'hFF);
    Reset = 1'b1;
    #1;
    check("async_reset_we", rf_we, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_pc", pc, RST_PC);
    check("async_reset_retired", retired, 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    m_ret = 16'h0000;
    @(posedge Clk); #1;
    check("post_reset_pc", pc, RST_PC);
    check("post_reset_req", imem_req, 0);
    check("post_reset_done", done, 0);
    check("post_reset_retired", retired, exp_retired());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_seq.md
# alu_issue_seq

Multi-cycle fetch/decode/issue sequencer that drives the combinational ALU in the 9-bit ISA datapath. It fetches 9-bit instructions over a req/ack instruction-memory port and decodes them into ALU opcode, condition code, register-file addresses and write-enable. It evaluates the ALU's condition flag to take branches and halts on the terminate condition. It sits between instruction memory and the register file/ALU pair.

## Interface
- PW, 8, program counter / instruction address width
- RESET_PC, 0, PC value loaded on reset and on Start
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  begin execution from RESET_PC; honoured only in IDLE or HALT
- imem_req  out  1  fetch request; held high until imem_ack
- imem_addr  out  PW  fetch address; always equals pc
- imem_ack  in  1  instruction valid this cycle; ignored outside FETCH
- imem_data  in  9  instruction word
- rf_raddr_a / rf_raddr_b  out  3  register read addresses feeding ALU InputA / InputB
- rf_waddr  out  3  writeback address
- rf_we  out  1  writeback strobe, one cycle
- alu_op  out  3  ALU opcode
- alu_cond  out  3  ALU condition code
- imm_sel  out  1  select imm_val instead of rf port B
- imm_val  out  8  zero-extended immediate
- cond_flag  in  1  ALU condition_flag
- pc  out  PW  current program counter
- busy  out  1  high in FETCH/DECODE/EXEC
- done  out  1  high in HALT
- retired  out  16  retired-instruction count

## Operation
- Instruction format, IR[8] selects the class.
  - ALU class (IR[8]=0): op=IR[7:5], rd=IR[4:2], rs=IR[1:0].
  - Branch class (IR[8]=1): cond=IR[7:5], off=IR[4:0], a signed offset.
- Decode, ALU class:
  - alu_op=IR[7:5]
  - rf_raddr_a=rd
  - rf_raddr_b={1'b0,rs}
  - rf_waddr=rd
  - imm_sel=1 when IR[7:5]==KMOVI (Definitions package); imm_val={6'b0,rs}
- Decode, branch class:
  - rf_raddr_a=0, rf_raddr_b=1
  - alu_cond=IR[7:5]
  - alu_op=KSUB
  - imm_sel=0
- Decode outputs are a function of IR only, so they are stable through EXEC.
- FSM states: IDLE, FETCH, DECODE, EXEC, HALT.
  - IDLE: Start → FETCH, with pc←RESET_PC.
  - FETCH: imem_req=1; on imem_ack, IR←imem_data → DECODE.
  - DECODE: one cycle for operand settle → EXEC.
  - EXEC, ALU class: rf_we=1; pc←pc+1 → FETCH.
  - EXEC, branch class, cond≠3'b111: cond_flag=1 gives pc←pc+sext(off), otherwise pc←pc+1 → FETCH.
  - EXEC, branch class, cond=3'b111: pc unchanged → HALT.
  - HALT: done=1; Start → FETCH, with pc←RESET_PC.
- PC arithmetic is modulo 2^PW, so wrap-around is silent. Offset 0 taken is a legal self-loop.
- Start is ignored while busy.
- retired increments by 1 on every EXEC cycle, including halt. It wraps at 2^16 and is cleared by Reset only.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, IR=0
  - imem_req=0, rf_we=0, busy=0, done=0, retired=0
  - decode outputs reflect IR=0: alu_op=0, addresses 0, imm_sel per op 0
- Reset mid-instruction aborts immediately. No writeback or PC update occurs.
- Minimum 3 cycles per instruction, when imem_ack arrives in the first FETCH cycle. Each extra ack-wait cycle adds 1.
- imem_req rises the cycle after Start is sampled. It remains high, with imem_addr stable, until the ack cycle inclusive.
- rf_we is high for exactly the EXEC cycle. The register file captures on the edge ending EXEC.
- cond_flag is sampled only on the edge ending EXEC.

## Configuration
- ALU_ISSUE_RETIRE_CNT_EN
  - Defined: the retired counter is implemented as described.
  - Undefined: retired is tied to 16'h0000 and no counter flops exist.
  - All other behaviour is identical in both cases.

## Test plan
- Reset, then Start, with ack on the first FETCH cycle and imem_data={0,KADD,rd=3,rs=1}:
  - imem_addr=0.
  - 3 cycles later rf_we=1, rf_waddr=3, rf_raddr_b=1, alu_op=KADD.
  - pc becomes 1.
- Branch 9'b1_001_11110 (eq, off=−2) at pc=5:
  - cond_flag=1 → pc=3.
  - cond_flag=0 → pc=6.
  - rf_we stays 0 in both cases.
- Branch 9'b1_111_00000 at pc=4:
  - done=1, busy=0, pc stays 4.
  - Start → FETCH at RESET_PC.
- PW=8, pc=8'hFF, ALU instruction → pc=8'h00.
  - Branch off=+1 at pc=8'hFF, taken → pc=8'h00.
- Hold imem_ack low for 4 cycles:
  - imem_req stays high and imem_addr is stable.
  - Spurious imem_ack pulses in DECODE or EXEC have no effect.
  - Start pulses while busy are ignored.
- Assert Reset during EXEC of an ALU instruction:
  - rf_we drops asynchronously, state=IDLE, pc=RESET_PC.
  - retired=0 with the macro, and 0 without it.
